// File: rtl/float2int_seq.sv
// Multi-cycle converter from the packed float word to a MAN-bit signed integer.
// The fraction is truncated by an iterative one-bit-per-cycle right shifter.
module float2int_seq #(
   parameter int MAN = 23,
   parameter int EXP = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [MAN+EXP:0]   in_float,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [MAN-1:0]     out_int,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_ovf,
   output logic               out_nan
);

   localparam int BIAS = 2**(EXP-1) - 1;
   localparam int CW   = $clog2(MAN+1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_SIGN  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Biased-exponent thresholds, one bit wider so BIAS+MAN cannot wrap.
   localparam logic [EXP:0] BIAS_V = (EXP+1)'(BIAS);
   localparam logic [EXP:0] EMAX_V = (EXP+1)'(BIAS + MAN - 1);
   localparam logic [EXP:0] MB_V   = (EXP+1)'(BIAS + MAN);

   localparam logic [MAN-1:0] SAT_POS = {1'b0, {(MAN-1){1'b1}}};
   localparam logic [MAN-1:0] SAT_NEG = {1'b1, {(MAN-1){1'b0}}};

   logic [1:0]     r_state;
   logic [MAN:0]   r_acc;
   logic [CW-1:0]  r_cnt;
   logic           r_sign;
   logic [MAN-1:0] r_out_int;
   logic           r_out_valid;
   logic           r_out_ovf;
   logic           r_out_nan;

   logic           w_sign;
   logic [EXP-1:0] w_exp;
   logic [MAN-1:0] w_man;
   logic [EXP:0]   w_exp_x;
   logic           w_exp_ones;
   logic           w_exp_zero;
   logic           w_man_zero;
   logic [MAN-1:0] w_sat;
   logic [CW-1:0]  w_shift_amt;
   logic           w_accept;
   logic           w_fast;
   logic [MAN-1:0] w_fast_int;
   logic           w_fast_ovf;
   logic           w_fast_nan;

   assign w_sign      = in_float[MAN+EXP];
   assign w_exp       = in_float[MAN+EXP-1:MAN];
   assign w_man       = in_float[MAN-1:0];
   assign w_exp_x     = {1'b0, w_exp};
   assign w_exp_ones  = &w_exp;
   assign w_exp_zero  = ~|w_exp;
   assign w_man_zero  = ~|w_man;
   assign w_sat       = w_sign ? SAT_NEG : SAT_POS;
   // Shift count MAN - e, only meaningful for 0 <= e <= MAN-2.
   assign w_shift_amt = CW'(MB_V - w_exp_x);
   assign w_accept    = in_valid & in_ready;

   assign in_ready  = (r_state == S_IDLE);
   assign out_int   = r_out_int;
   assign out_valid = r_out_valid;
   assign out_ovf   = r_out_ovf;
   assign out_nan   = r_out_nan;

   // Single-cycle classification of everything that does not need shifting.
   always_comb begin
      w_fast     = 1'b1;
      w_fast_int = '0;
      w_fast_ovf = 1'b0;
      w_fast_nan = 1'b0;
      if (w_exp_ones && !w_man_zero) begin
         w_fast_nan = 1'b1;
      end else if (w_exp_ones) begin
         w_fast_int = w_sat;
         w_fast_ovf = 1'b1;
      end else if (w_exp_zero || (w_exp_x < BIAS_V)) begin
         w_fast_int = '0;
      end else if (w_exp_x > EMAX_V) begin
         w_fast_int = w_sat;
         w_fast_ovf = 1'b1;
      end else if (w_exp_x == EMAX_V) begin
         // Only -2^(MAN-1) itself is representable at this exponent.
         w_fast_int = w_sat;
         w_fast_ovf = !(w_sign && w_man_zero);
      end else begin
         w_fast     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_sign      <= 1'b0;
         r_out_int   <= '0;
         r_out_valid <= 1'b0;
         r_out_ovf   <= 1'b0;
         r_out_nan   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sign <= w_sign;
                  if (w_fast) begin
                     r_out_int   <= w_fast_int;
                     r_out_ovf   <= w_fast_ovf;
                     r_out_nan   <= w_fast_nan;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_acc   <= {1'b1, w_man};
                     r_cnt   <= w_shift_amt;
                     r_state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               r_acc <= r_acc >> 1;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_state <= S_SIGN;
               end
            end
            S_SIGN: begin
               r_out_int   <= r_sign ? -r_acc[MAN-1:0] : r_acc[MAN-1:0];
               r_out_ovf   <= 1'b0;
               r_out_nan   <= 1'b0;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_out_ovf   <= 1'b0;
                  r_out_nan   <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_float2int_seq.sv
// Directed bench for float2int_seq: one task per scenario, inline checks,
// one printed line per conversion.
module tb_float2int_seq;

   logic        clk;
   logic        rst;
   logic [31:0] in_float;
   logic        in_valid;
   logic        in_ready;
   logic [22:0] out_int;
   logic        out_valid;
   logic        out_ready;
   logic        out_ovf;
   logic        out_nan;

   int total = 0;
   int bad   = 0;

   float2int_seq #(.MAN(23), .EXP(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_float  (in_float),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_int   (out_int),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ovf   (out_ovf),
      .out_nan   (out_nan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Truncating reference for exponents below 2^22 (e <= 21).
   function automatic logic [22:0] ref_trunc(input logic [31:0] f);
      logic [23:0] sig;
      logic [22:0] mag;
      int          e;
      e = int'(f[30:23]) - 127;
      if (f[30:23] == 8'd0 || e < 0) return 23'd0;
      sig = {1'b1, f[22:0]};
      mag = 23'(sig >> (23 - e));
      return f[31] ? -mag : mag;
   endfunction

   // Drives one conversion from IDLE and completes the output handshake.
   // lat = edges from accept to out_valid, or -1 on timeout.
   task automatic do_conv(input logic [31:0] f, output logic [22:0] r,
                          output logic ovf, output logic nan, output int lat);
      in_float = f;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      r   = out_int;
      ovf = out_ovf;
      nan = out_nan;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_int !== 23'd0 ||
          out_ovf !== 1'b0 || out_nan !== 1'b0) begin
         bad++;
         $display("FAIL reset: valid=%b ready=%b int=%h ovf=%b nan=%b, want 0 1 000000 0 0",
                  out_valid, in_ready, out_int, out_ovf, out_nan);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_vectors();
      logic [31:0] vf   [13] = '{32'h3F800000, 32'hC0200000, 32'h4A7FFFFE, 32'hCA800000,
                                 32'h4B000000, 32'hFF800000, 32'h7FC00000, 32'h3F400000,
                                 32'h00000000, 32'h4A800000, 32'h7F800000, 32'h00400000,
                                 32'hBF800000};
      logic [22:0] vint [13] = '{23'h000001, 23'h7FFFFE, 23'h3FFFFF, 23'h400000,
                                 23'h3FFFFF, 23'h400000, 23'h000000, 23'h000000,
                                 23'h000000, 23'h3FFFFF, 23'h3FFFFF, 23'h000000,
                                 23'h7FFFFF};
      logic        vovf [13] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
      logic        vnan [13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
      int          vlat [13] = '{25, 24, 4, 1, 1, 1, 1, 1, 1, 1, 1, 1, 25};
      logic [22:0] r;
      logic        ovf, nan;
      int          lat;
      for (int i = 0; i < 13; i++) begin
         do_conv(vf[i], r, ovf, nan, lat);
         $display("vec %h -> int=%h ovf=%b nan=%b lat=%0d", vf[i], r, ovf, nan, lat);
         total++;
         if (r !== vint[i] || ovf !== vovf[i] || nan !== vnan[i]) begin
            bad++;
            $display("FAIL vec_%h: int=%h ovf=%b nan=%b, want int=%h ovf=%b nan=%b",
                     vf[i], r, ovf, nan, vint[i], vovf[i], vnan[i]);
         end
         total++;
         if (lat !== vlat[i]) begin
            bad++;
            $display("FAIL lat_%h: latency=%0d, want %0d", vf[i], lat, vlat[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat = 0;
      int unstable = 0;
      int extra = 0;
      in_float = 32'h4B000000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_float = 32'h3F800000;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (!out_valid) begin
         bad++;
         $display("FAIL bp_valid: out_valid=%b, want 1", out_valid);
      end
      for (int c = 0; c < 10; c++) begin
         if (out_valid !== 1'b1 || out_int !== 23'h3FFFFF || out_ovf !== 1'b1 ||
             out_nan !== 1'b0 || in_ready !== 1'b0) unstable++;
         @(posedge clk); #1;
      end
      total++;
      if (unstable != 0) begin
         bad++;
         $display("FAIL bp_hold: %0d unstable cycles, want 0", unstable);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      $display("bp 4B000000 held 10 cycles, released");
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ovf !== 1'b0) begin
         bad++;
         $display("FAIL bp_release: valid=%b ready=%b ovf=%b, want 0 1 0",
                  out_valid, in_ready, out_ovf);
      end
      for (int c = 0; c < 30; c++) begin
         if (out_valid) extra++;
         @(posedge clk); #1;
      end
      total++;
      if (extra != 0) begin
         bad++;
         $display("FAIL bp_ignored: %0d valid cycles from ignored input, want 0", extra);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [22:0] r;
      logic        ovf, nan;
      int          lat;
      int          stale = 0;
      in_float = 32'h3F800000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (out_valid !== 1'b0 || out_int !== 23'd0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_shift: valid=%b int=%h ready=%b, want 0 000000 1",
                  out_valid, out_int, in_ready);
      end
      for (int c = 0; c < 40; c++) begin
         if (out_valid) stale++;
         @(posedge clk); #1;
      end
      total++;
      if (stale != 0) begin
         bad++;
         $display("FAIL rst_stale: %0d valid cycles after reset, want 0", stale);
      end
      do_conv(32'h40400000, r, ovf, nan, lat);
      $display("post-reset 40400000 -> int=%h ovf=%b nan=%b lat=%0d", r, ovf, nan, lat);
      total++;
      if (r !== 23'd3 || ovf !== 1'b0 || nan !== 1'b0 || lat !== 24) begin
         bad++;
         $display("FAIL rst_after: int=%h ovf=%b nan=%b lat=%0d, want 000003 0 0 24",
                  r, ovf, nan, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] stim [16];
      logic [22:0] expv [16];
      int          k = 0;
      int          j = 0;
      int          cyc = 0;
      int          extra = 0;
      logic        acc;
      for (int i = 0; i < 16; i++) begin
         stim[i] = {1'($urandom_range(1, 0)), 8'($urandom_range(148, 120)), 23'($urandom)};
         expv[i] = ref_trunc(stim[i]);
      end
      out_ready = 1'b1;
      in_float  = stim[0];
      in_valid  = 1'b1;
      while (j < 16 && cyc < 3000) begin
         acc = in_valid & in_ready;
         if (out_valid) begin
            $display("b2b %0d -> int=%h ovf=%b nan=%b", j, out_int, out_ovf, out_nan);
            total++;
            if (out_int !== expv[j] || out_ovf !== 1'b0 || out_nan !== 1'b0) begin
               bad++;
               $display("FAIL b2b_%0d: int=%h ovf=%b nan=%b, want int=%h flags 0 (in %h)",
                        j, out_int, out_ovf, out_nan, expv[j], stim[j]);
            end
            j++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            k++;
            if (k < 16) in_float = stim[k];
            else        in_valid = 1'b0;
         end
      end
      total++;
      if (j != 16 || k != 16) begin
         bad++;
         $display("FAIL b2b_count: accepted=%0d results=%0d, want 16 16", k, j);
      end
      for (int c = 0; c < 40; c++) begin
         if (out_valid) extra++;
         @(posedge clk); #1;
      end
      total++;
      if (extra != 0) begin
         bad++;
         $display("FAIL b2b_dup: %0d extra results, want 0", extra);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_float  = 32'd0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_mid_shift();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
